// File: rtl/xor_pattern_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// xor_ctrl_pkg
// Shared types and constants for the XOR VGA pattern controller.
//   mode_t   : scroll mode encoding (STATIC / SCROLL_X / SCROLL_XY)
//   MOD_*    : modulus limits and reset value
//   PALETTE  : rrggbb colours selected by the palette index
// ----------------------------------------------------------------------------
package xor_ctrl_pkg;

   typedef enum logic [1:0] {
      STATIC    = 2'd0,
      SCROLL_X  = 2'd1,
      SCROLL_XY = 2'd2
   } mode_t;

   localparam logic [3:0] MOD_MIN   = 4'd2;
   localparam logic [3:0] MOD_MAX   = 4'd15;
   localparam logic [3:0] MOD_RESET = 4'd9;

   localparam logic [5:0] PALETTE [8] = '{
      6'b111111, 6'b110000, 6'b001100, 6'b000011,
      6'b111100, 6'b001111, 6'b110011, 6'b010101
   };

endpackage

// File: rtl/xor_pattern_ctrl_debounce.sv
// ----------------------------------------------------------------------------
// button_debounce
// Two-flop synchronizer followed by a level debouncer. The debounced level
// only follows the synchronized input after it has disagreed for
// DEBOUNCE_CYCLES consecutive cycles; any agreement reloads the timer.
// o_rise pulses for one cycle on the edge where the level goes 0->1.
// Ports:
//   i_clk  : clock
//   i_rst  : asynchronous reset, active high
//   i_btn  : raw asynchronous button, pressed = 1
//   o_rise : one-cycle debounced press event
// ----------------------------------------------------------------------------
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_btn,
   output logic o_rise
);

   localparam int             CW       = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]  CNT_LOAD = CW'(DEBOUNCE_CYCLES - 1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_level;
   logic          r_rise;
   logic [CW-1:0] r_cnt;

   // Down-counter runs only while input and level disagree; terminal count
   // on a disagreeing cycle means DEBOUNCE_CYCLES disagreements in a row.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_level <= 1'b0;
         r_rise  <= 1'b0;
         r_cnt   <= CNT_LOAD;
      end else begin
         r_sync1 <= i_btn;
         r_sync2 <= r_sync1;
         r_rise  <= 1'b0;
         if (r_sync2 == r_level) begin
            r_cnt <= CNT_LOAD;
         end else if (r_cnt == '0) begin
            r_level <= r_sync2;
            r_rise  <= r_sync2;
            r_cnt   <= CNT_LOAD;
         end else begin
            r_cnt <= r_cnt - 1'b1;
         end
      end
   end

   assign o_rise = r_rise;

endmodule

// File: rtl/xor_pattern_ctrl.sv
// ----------------------------------------------------------------------------
// xor_pattern_ctrl
// Frame-synchronous parameter controller for the XOR VGA pattern. Debounced
// button presses are latched as pending flags and applied together at the
// start of vertical sync, so the pixel datapath never sees a mid-frame change.
// Build option: define XOR_CTRL_AUTOSCROLL_EN to include but3, the mode FSM
// and the scroll offset accumulators; otherwise mode and offsets are 0.
// Ports:
//   px_clk, reset        : pixel clock, async active-high reset
//   but1/but2/but3       : raw buttons (modulus / colour / scroll mode)
//   vsync                : from the sync generator, polarity VSYNC_ACTIVE_LOW
//   modulus, match       : divisor and lit residue for (x^y) % modulus
//   x_off, y_off         : scroll offsets added before the XOR
//   colour               : rrggbb of lit pixels
//   mode                 : 0 STATIC, 1 SCROLL_X, 2 SCROLL_XY
//   frame_tick           : one-cycle pulse on the update edge
//
// Mode FSM:
//   state     | meaning
//   STATIC    | offsets held at 0
//   SCROLL_X  | x_off advances SCROLL_STEP per frame
//   SCROLL_XY | x_off and y_off advance SCROLL_STEP per frame
// ----------------------------------------------------------------------------
module xor_pattern_ctrl
   import xor_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES  = 250000,
   parameter int SCROLL_STEP      = 1,
   parameter int VSYNC_ACTIVE_LOW = 1
) (
   input  logic       px_clk,
   input  logic       reset,
   input  logic       but1,
   input  logic       but2,
   input  logic       but3,
   input  logic       vsync,
   output logic [3:0] modulus,
   output logic [3:0] match,
   output logic [9:0] x_off,
   output logic [9:0] y_off,
   output logic [5:0] colour,
   output logic [1:0] mode,
   output logic       frame_tick
);

   logic       w_vs_act;
   logic       r_vs;
   logic       r_vs_d;
   logic       w_frame_start;
   logic       w_rise1;
   logic       w_rise2;
   logic       r_pend1;
   logic       r_pend2;
   logic       w_ev1;
   logic       w_ev2;
   logic [3:0] w_mod_inc;
   logic [2:0] w_pal_nxt;
   logic [3:0] r_mod;
   logic [3:0] r_match;
   logic [2:0] r_pal_idx;
   logic [5:0] r_colour;
   logic       r_tick;

   assign w_vs_act = (VSYNC_ACTIVE_LOW != 0) ? ~vsync : vsync;

   // Sync history resets to "already active" so a vsync that is active while
   // reset is released does not fire a tick; the next real assertion does.
   always_ff @(posedge px_clk or posedge reset) begin
      if (reset) begin
         r_vs   <= 1'b1;
         r_vs_d <= 1'b1;
      end else begin
         r_vs   <= w_vs_act;
         r_vs_d <= r_vs;
      end
   end

   assign w_frame_start = r_vs & ~r_vs_d;

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db1 (
      .i_clk(px_clk), .i_rst(reset), .i_btn(but1), .o_rise(w_rise1)
   );
   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db2 (
      .i_clk(px_clk), .i_rst(reset), .i_btn(but2), .o_rise(w_rise2)
   );

   // A rise coinciding with frame start is folded in here so it is not lost
   // when the pending flags clear on that same edge.
   assign w_ev1 = r_pend1 | w_rise1;
   assign w_ev2 = r_pend2 | w_rise2;

   always_ff @(posedge px_clk or posedge reset) begin
      if (reset) begin
         r_pend1 <= 1'b0;
         r_pend2 <= 1'b0;
      end else if (w_frame_start) begin
         r_pend1 <= 1'b0;
         r_pend2 <= 1'b0;
      end else begin
         if (w_rise1) r_pend1 <= 1'b1;
         if (w_rise2) r_pend2 <= 1'b1;
      end
   end

   assign w_mod_inc = (r_mod == MOD_MAX) ? MOD_MIN : r_mod + 4'd1;
   assign w_pal_nxt = r_pal_idx + 3'd1;

   always_ff @(posedge px_clk or posedge reset) begin
      if (reset) begin
         r_tick    <= 1'b0;
         r_mod     <= MOD_RESET;
         r_match   <= 4'd1;
         r_pal_idx <= 3'd0;
         r_colour  <= PALETTE[0];
      end else begin
         r_tick <= w_frame_start;
         if (w_frame_start && w_ev1) begin
            r_mod <= w_mod_inc;
            if (r_match >= w_mod_inc) r_match <= 4'd1;
         end
         if (w_frame_start && w_ev2) begin
            r_pal_idx <= w_pal_nxt;
            r_colour  <= PALETTE[w_pal_nxt];
         end
      end
   end

   assign modulus    = r_mod;
   assign match      = r_match;
   assign colour     = r_colour;
   assign frame_tick = r_tick;

`ifdef XOR_CTRL_AUTOSCROLL_EN
   logic       w_rise3;
   logic       r_pend3;
   logic       w_ev3;
   mode_t      r_mode;
   mode_t      w_mode_nxt;
   logic [9:0] r_x_off;
   logic [9:0] r_y_off;

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db3 (
      .i_clk(px_clk), .i_rst(reset), .i_btn(but3), .o_rise(w_rise3)
   );

   assign w_ev3 = r_pend3 | w_rise3;

   always_ff @(posedge px_clk or posedge reset) begin
      if (reset)              r_pend3 <= 1'b0;
      else if (w_frame_start) r_pend3 <= 1'b0;
      else if (w_rise3)       r_pend3 <= 1'b1;
   end

   always_ff @(posedge px_clk or posedge reset) begin
      if (reset) r_mode <= STATIC;
      else       r_mode <= w_mode_nxt;
   end

   always_comb begin
      w_mode_nxt = r_mode;
      if (w_frame_start && w_ev3) begin
         case (r_mode)
            STATIC:   w_mode_nxt = SCROLL_X;
            SCROLL_X: w_mode_nxt = SCROLL_XY;
            default:  w_mode_nxt = STATIC;
         endcase
      end
   end

   // Offsets follow the post-update mode, so the first scrolling frame
   // already advances by one step.
   always_ff @(posedge px_clk or posedge reset) begin
      if (reset) begin
         r_x_off <= 10'd0;
         r_y_off <= 10'd0;
      end else if (w_frame_start) begin
         case (w_mode_nxt)
            SCROLL_X: r_x_off <= r_x_off + 10'(SCROLL_STEP);
            SCROLL_XY: begin
               r_x_off <= r_x_off + 10'(SCROLL_STEP);
               r_y_off <= r_y_off + 10'(SCROLL_STEP);
            end
            default: begin
               r_x_off <= 10'd0;
               r_y_off <= 10'd0;
            end
         endcase
      end
   end

   assign mode  = r_mode;
   assign x_off = r_x_off;
   assign y_off = r_y_off;
`else
   logic       w_unused_but3;
   logic [9:0] w_unused_step;

   assign w_unused_but3 = but3;
   assign w_unused_step = 10'(SCROLL_STEP);
   assign mode          = 2'd0;
   assign x_off         = 10'd0;
   assign y_off         = 10'd0;
`endif

endmodule

// File: tb/tb_xor_pattern_ctrl.sv
// ----------------------------------------------------------------------------
// tb_xor_pattern_ctrl
// Directed scoreboard bench: each frame's expected register snapshot is
// queued before vsync is driven; a monitor pops and compares on frame_tick.
// ----------------------------------------------------------------------------
module tb_xor_pattern_ctrl;

   logic       px_clk = 1'b0;
   logic       reset  = 1'b1;
   logic       but1   = 1'b0;
   logic       but2   = 1'b0;
   logic       but3   = 1'b0;
   logic       vsync  = 1'b1;
   logic [3:0] modulus;
   logic [3:0] match;
   logic [9:0] x_off;
   logic [9:0] y_off;
   logic [5:0] colour;
   logic [1:0] mode;
   logic       frame_tick;

   xor_pattern_ctrl #(
      .DEBOUNCE_CYCLES(4), .SCROLL_STEP(3), .VSYNC_ACTIVE_LOW(1)
   ) dut (
      .px_clk(px_clk), .reset(reset), .but1(but1), .but2(but2), .but3(but3),
      .vsync(vsync), .modulus(modulus), .match(match), .x_off(x_off),
      .y_off(y_off), .colour(colour), .mode(mode), .frame_tick(frame_tick)
   );

   always #5 px_clk = ~px_clk;

   typedef struct packed {
      logic [3:0] md;
      logic [3:0] mt;
      logic [5:0] col;
      logic [1:0] mode;
      logic [9:0] x;
      logic [9:0] y;
   } snap_t;

   localparam snap_t RST = '{md: 4'd9, mt: 4'd1, col: 6'b111111, mode: 2'd0,
                             x: 10'd0, y: 10'd0};

   logic [5:0] pal [8] = '{6'b111111, 6'b110000, 6'b001100, 6'b000011,
                           6'b111100, 6'b001111, 6'b110011, 6'b010101};

   snap_t q[$];
   snap_t m_cur;
   snap_t m_prev;
   int    n_vec  = 0;
   int    n_miss = 0;

   function automatic snap_t actual();
      snap_t s;
      s.md = modulus; s.mt = match; s.col = colour; s.mode = mode;
      s.x = x_off; s.y = y_off;
      return s;
   endfunction

   task automatic chk(input string nm, input snap_t a, input snap_t e);
      n_vec++;
      if (a !== e) begin
         n_miss++;
         $display("FAIL %s: got mod=%0d match=%0d colour=%b mode=%0d x=%0d y=%0d | want mod=%0d match=%0d colour=%b mode=%0d x=%0d y=%0d",
                  nm, a.md, a.mt, a.col, a.mode, a.x, a.y,
                  e.md, e.mt, e.col, e.mode, e.x, e.y);
      end
   endtask

   task automatic chk_bit(input string nm, input logic a, input logic e);
      n_vec++;
      if (a !== e) begin
         n_miss++;
         $display("FAIL %s: got %b want %b", nm, a, e);
      end
   endtask

   // Monitor: every frame_tick must consume exactly one queued expectation.
   always @(negedge px_clk) begin
      if (frame_tick === 1'b1) begin
         if (q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected_tick: frame_tick high with no frame expected at %0t", $time);
         end else begin
            chk("frame_apply", actual(), q.pop_front());
         end
      end
   end

   task automatic frame_core();
      bit seen;
      seen  = 1'b0;
      vsync = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
         @(negedge px_clk);
         if (frame_tick === 1'b1) seen = 1'b1;
      end
      n_vec++;
      if (!seen) begin
         n_miss++;
         $display("FAIL tick_timeout: frame_tick got 0 within 8 cycles, want 1");
      end
      repeat (3) @(negedge px_clk);
      vsync = 1'b1;
      repeat (4) @(negedge px_clk);
   endtask

   task automatic do_frame();
      chk("hold_before_frame", actual(), m_prev);
      q.push_back(m_cur);
      m_prev = m_cur;
      @(negedge px_clk);
      frame_core();
   endtask

   task automatic press(input int b, input int len);
      @(negedge px_clk);
      case (b)
         1: but1 = 1'b1;
         2: but2 = 1'b1;
         default: but3 = 1'b1;
      endcase
      repeat (len) @(negedge px_clk);
      but1 = 1'b0; but2 = 1'b0; but3 = 1'b0;
      repeat (12) @(negedge px_clk);
   endtask

   initial begin
      repeat (3) @(negedge px_clk);
      chk("reset_values", actual(), RST);
      chk_bit("reset_tick", frame_tick, 1'b0);
      reset  = 1'b0;
      m_cur  = RST;
      m_prev = RST;
      repeat (5) @(negedge px_clk);

      // 3-cycle glitch is rejected
      press(1, 3);
      do_frame();

      // accepted press, only at the frame edge
      press(1, 20);
      m_cur.md = 4'd10;
      do_frame();

      // 4-cycle press is exactly long enough
      for (int k = 11; k <= 15; k++) begin
         press(1, (k == 11) ? 4 : 20);
         m_cur.md = 4'(k);
         do_frame();
      end
      press(1, 20);
      m_cur.md = 4'd2;
      m_cur.mt = 4'd1;
      do_frame();

      // colour walks the palette and wraps
      for (int i = 1; i <= 8; i++) begin
         press(2, 20);
         m_cur.col = pal[i % 8];
         do_frame();
      end
      press(2, 20);
      press(2, 20);
      m_cur.col = pal[1];
      do_frame();

      // debounced rise lands in the same cycle as frame start
      chk("hold_before_simul", actual(), m_prev);
      m_cur.col = pal[2];
      q.push_back(m_cur);
      m_prev = m_cur;
      @(negedge px_clk);
      but2 = 1'b1;
      repeat (5) @(negedge px_clk);
      frame_core();
      but2 = 1'b0;
      repeat (12) @(negedge px_clk);
      do_frame();

`ifdef XOR_CTRL_AUTOSCROLL_EN
      press(3, 20);
      m_cur.mode = 2'd1;
      m_cur.x    = 10'd3;
      do_frame();
      for (int k = 2; k <= 342; k++) begin
         m_cur.x = 10'(3 * k);
         do_frame();
      end
      chk("x_wrap", actual(), '{md: 4'd2, mt: 4'd1, col: 6'b001100, mode: 2'd1,
                                x: 10'd2, y: 10'd0});
      press(3, 20);
      m_cur.mode = 2'd2; m_cur.x = 10'd5; m_cur.y = 10'd3;
      do_frame();
      m_cur.x = 10'd8; m_cur.y = 10'd6;
      do_frame();
      press(3, 20);
      m_cur.mode = 2'd0; m_cur.x = 10'd0; m_cur.y = 10'd0;
      do_frame();
      do_frame();
`else
      press(3, 20);
      do_frame();
      press(3, 20);
      do_frame();
`endif

      // asynchronous reset mid-frame and mid-debounce
      @(negedge px_clk);
      but1 = 1'b1;
      repeat (3) @(negedge px_clk);
      #2 reset = 1'b1;
      #1;
      chk("reset_async", actual(), RST);
      chk_bit("reset_async_tick", frame_tick, 1'b0);
      @(negedge px_clk);
      but1  = 1'b0;
      reset = 1'b0;
      m_cur  = RST;
      m_prev = RST;
      repeat (30) @(negedge px_clk);
      do_frame();

      n_vec++;
      if (q.size() != 0) begin
         n_miss++;
         $display("FAIL queue_drain: got %0d frames unconsumed, want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      n_miss++;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $fatal(1, "watchdog");
   end

endmodule
